// File: rtl/lcd_hd44780_capture.sv
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_capture
// Purpose  : Receiving end of an 8-bit HD44780 character-LCD bus. Every write
//            strobe (falling edge of E) is decoded into a command or a data
//            write. The block keeps a 2-line x NCOLS character buffer plus the
//            cursor/display state, and exposes the buffer via a registered
//            read port so a host-side simulator can mirror the panel.
// Ports    : clk_i          system clock
//            reset_i        synchronous, active-high reset
//            lcd_rs_i       bus RS (0 = command, 1 = data), async to clk_i
//            lcd_e_i        bus E strobe, write taken on its falling edge
//            lcd_d_i[7:0]   bus data
//            rd_addr_i      buffer index (line 0: 0..NCOLS-1, line 1: NCOLS..)
//            rd_data_o      buffer[rd_addr_i], one cycle latency
//            cursor_addr_o  DDRAM address counter
//            display_on_o   display-control D bit
//            cursor_on_o    display-control C bit
//            blink_on_o     display-control B bit
//            busy_o         clear sequencer running
//            update_o       one-cycle pulse after any buffer/state change
//            overrun_o      sticky: a strobe arrived while busy and was dropped
// Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_capture #(
  parameter int         NCOLS = 16,
  parameter logic [7:0] BLANK = 8'h20,
  localparam int        AW    = $clog2(2*NCOLS)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          lcd_rs_i,
  input  logic          lcd_e_i,
  input  logic [7:0]    lcd_d_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [7:0]    rd_data_o,
  output logic [6:0]    cursor_addr_o,
  output logic          display_on_o,
  output logic          cursor_on_o,
  output logic          blink_on_o,
  output logic          busy_o,
  output logic          update_o,
  output logic          overrun_o
);

  localparam int            c_DEPTH    = 2*NCOLS;
  localparam logic [AW-1:0] c_LAST_IDX = AW'(c_DEPTH-1);
  localparam logic [6:0]    c_NCOLS7   = 7'(NCOLS);
  localparam logic [6:0]    c_LINE1    = 7'h40;
  localparam logic [6:0]    c_LINE1_END = 7'(64 + NCOLS);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_CLEAR = 1'b1;

  // --------------------------------------------------------------------------
  // Input synchronizer (2 flops) followed by a "prev" stage. RS/D are taken
  // from the prev stage, i.e. the values present while E was still high.
  // --------------------------------------------------------------------------
  logic       rs_meta_q, rs_sync_q, rs_prev_q;
  logic       e_meta_q,  e_sync_q,  e_prev_q;
  logic [7:0] d_meta_q,  d_sync_q,  d_prev_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rs_meta_q <= 1'b0;
      rs_sync_q <= 1'b0;
      rs_prev_q <= 1'b0;
      e_meta_q  <= 1'b0;
      e_sync_q  <= 1'b0;
      e_prev_q  <= 1'b0;
      d_meta_q  <= 8'h00;
      d_sync_q  <= 8'h00;
      d_prev_q  <= 8'h00;
    end else begin
      rs_meta_q <= lcd_rs_i;
      rs_sync_q <= rs_meta_q;
      rs_prev_q <= rs_sync_q;
      e_meta_q  <= lcd_e_i;
      e_sync_q  <= e_meta_q;
      e_prev_q  <= e_sync_q;
      d_meta_q  <= lcd_d_i;
      d_sync_q  <= d_meta_q;
      d_prev_q  <= d_sync_q;
    end
  end

  logic w_strobe;
  assign w_strobe = e_prev_q & ~e_sync_q;

  // --------------------------------------------------------------------------
  // Cursor movement on the 2-line DDRAM map: the end of each visible line
  // region (0x27 / 0x67) wraps to the start of the other line.
  // --------------------------------------------------------------------------
  function automatic logic [6:0] f_move(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // State / datapath registers
  // --------------------------------------------------------------------------
  logic [0:0]    state_q,   state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [6:0]    cursor_q,  cursor_d;
  logic          id_q,      id_d;
  logic          cgram_q,   cgram_d;
  logic          disp_q,    disp_d;
  logic          curs_q,    curs_d;
  logic          blink_q,   blink_d;
  logic          update_q,  update_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    rd_data_q, rd_data_d;

  logic          w_clr_start;
  logic          w_data_we;
  logic          w_clearing;

  // Buffer index for the current cursor address
  logic          w_in_line0, w_in_line1;
  logic [6:0]    w_wr_idx7;
  logic [AW-1:0] w_wr_idx;

  assign w_in_line0 = (cursor_q < c_NCOLS7);
  assign w_in_line1 = (cursor_q >= c_LINE1) && (cursor_q < c_LINE1_END);
  assign w_wr_idx7  = w_in_line0 ? cursor_q : (cursor_q - c_LINE1 + c_NCOLS7);
  assign w_wr_idx   = w_wr_idx7[AW-1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= c_ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_clr_start) begin
          state_d   = c_ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      c_ST_CLEAR: begin
        if (clr_idx_q == c_LAST_IDX) begin
          state_d   = c_ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 1'b1;
        end
      end
      default: begin
        state_d   = c_ST_IDLE;
        clr_idx_d = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_clearing = (state_q == c_ST_CLEAR);
    busy_o     = w_clearing;
  end

  // --------------------------------------------------------------------------
  // Strobe decode
  // --------------------------------------------------------------------------
  always_comb begin
    cursor_d    = cursor_q;
    id_d        = id_q;
    cgram_d     = cgram_q;
    disp_d      = disp_q;
    curs_d      = curs_q;
    blink_d     = blink_q;
    update_d    = 1'b0;
    overrun_d   = overrun_q;
    w_clr_start = 1'b0;
    w_data_we   = 1'b0;

    if (w_strobe) begin
      if (w_clearing) begin
        overrun_d = 1'b1;
      end else if (!rs_prev_q) begin
        // Highest set bit selects the command.
        casez (d_prev_q)
          8'b1???????: begin
            cursor_d = d_prev_q[6:0];
            cgram_d  = 1'b0;
            update_d = 1'b1;
          end
          8'b01??????: begin
            cgram_d  = 1'b1;
            update_d = 1'b1;
          end
          8'b001?????: begin
            // function set: nothing to mirror
          end
          8'b0001????: begin
            // D[3]=1 is a display shift, which is not mirrored
            if (!d_prev_q[3]) begin
              cursor_d = f_move(cursor_q, d_prev_q[2]);
              update_d = 1'b1;
            end
          end
          8'b00001???: begin
            disp_d   = d_prev_q[2];
            curs_d   = d_prev_q[1];
            blink_d  = d_prev_q[0];
            update_d = 1'b1;
          end
          8'b000001??: begin
            id_d     = d_prev_q[1];
            update_d = 1'b1;
          end
          8'b0000001?: begin
            cursor_d = 7'h00;
            update_d = 1'b1;
          end
          8'b00000001: begin
            w_clr_start = 1'b1;
            cursor_d    = 7'h00;
            id_d        = 1'b1;
            cgram_d     = 1'b0;
            update_d    = 1'b1;
          end
          default: begin
          end
        endcase
      end else if (!cgram_q) begin
        // Address advances even when the write lands off-screen.
        w_data_we = w_in_line0 | w_in_line1;
        cursor_d  = f_move(cursor_q, id_q);
        update_d  = 1'b1;
      end
    end

    if (w_clearing && (clr_idx_q == c_LAST_IDX)) begin
      update_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cursor_q  <= 7'h00;
      id_q      <= 1'b1;
      cgram_q   <= 1'b0;
      disp_q    <= 1'b0;
      curs_q    <= 1'b0;
      blink_q   <= 1'b0;
      update_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      cursor_q  <= cursor_d;
      id_q      <= id_d;
      cgram_q   <= cgram_d;
      disp_q    <= disp_d;
      curs_q    <= curs_d;
      blink_q   <= blink_d;
      update_q  <= update_d;
      overrun_q <= overrun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Character buffer: single write port (clear sequencer or data write),
  // registered read port.
  // --------------------------------------------------------------------------
  logic [7:0]    mem_q [c_DEPTH];
  logic          w_mem_we;
  logic [AW-1:0] w_mem_widx;
  logic [7:0]    w_mem_wdata;

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_widx  = w_wr_idx;
    w_mem_wdata = d_prev_q;
    if (w_clearing) begin
      w_mem_we    = 1'b1;
      w_mem_widx  = clr_idx_q;
      w_mem_wdata = BLANK;
    end else if (w_data_we) begin
      w_mem_we    = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_mem_we) begin
      mem_q[w_mem_widx] <= w_mem_wdata;
    end
  end

  // Out-of-range read detection only exists when the index space is larger
  // than the buffer.
  logic w_rd_valid;
  generate
    if (c_DEPTH == (1 << AW)) begin : g_rd_full
      assign w_rd_valid = 1'b1;
    end else begin : g_rd_part
      assign w_rd_valid = (int'(rd_addr_i) < c_DEPTH);
    end
  endgenerate

  assign rd_data_d = w_rd_valid ? mem_q[rd_addr_i] : 8'h00;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign cursor_addr_o = cursor_q;
  assign display_on_o  = disp_q;
  assign cursor_on_o   = curs_q;
  assign blink_on_o    = blink_q;
  assign update_o      = update_q;
  assign overrun_o     = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_hd44780_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_hd44780_capture
// Purpose  : Directed self-checking bench for lcd_hd44780_capture (NCOLS=16).
//            Drives HD44780 bus writes and compares buffer contents, cursor
//            address and status outputs against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_hd44780_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       lcd_rs;
  logic       lcd_e;
  logic [7:0] lcd_d;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, busy, update, overrun;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;

  always #5 clk = ~clk;

  lcd_hd44780_capture #(.NCOLS(16), .BLANK(8'h20)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .lcd_rs_i      (lcd_rs),
    .lcd_e_i       (lcd_e),
    .lcd_d_i       (lcd_d),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .cursor_addr_o (cursor_addr),
    .display_on_o  (display_on),
    .cursor_on_o   (cursor_on),
    .blink_on_o    (blink_on),
    .busy_o        (busy),
    .update_o      (update),
    .overrun_o     (overrun)
  );

  // update is a one-cycle pulse, so each pulse is seen at exactly one negedge
  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt = upd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Full bus write with settle time for sync + decode
  task automatic wr(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs;
    lcd_d  = d;
    lcd_e  = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e  = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic rdbuf(input int idx, output logic [7:0] v);
    @(negedge clk);
    rd_addr = idx[4:0];
    @(negedge clk);
    v = rd_data;
  endtask

  task automatic chk_buf(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] v;
    rdbuf(idx, v);
    chk(tag, {24'h0, v}, {24'h0, exp});
  endtask

  // Called on the negedge where reset is released; counts busy cycles
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_rise(input string tag);
    int n = 0;
    while (busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, busy}, 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int nb;
    int base;
    reset   = 1'b1;
    lcd_rs  = 1'b0;
    lcd_e   = 1'b0;
    lcd_d   = 8'h00;
    rd_addr = 5'd0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    chk("rst_rd_data", {24'h0, rd_data}, 32'h0);
    chk("rst_cursor",  {25'h0, cursor_addr}, 32'h0);
    chk("rst_disp",    {29'h0, display_on, cursor_on, blink_on}, 32'h0);
    chk("rst_update",  {31'h0, update}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
    reset = 1'b0;
    count_busy(nb);
    chk("clear_len", nb, 32);
    chk("clear_done_update", {31'h0, update}, 32'h1);
    for (int i = 0; i < 32; i++) chk_buf("blank_after_reset", i, 8'h20);
    chk("post_rst_cursor", {25'h0, cursor_addr}, 32'h0);
    chk("post_rst_disp", {31'h0, display_on}, 32'h0);

    // ---------------- display control, entry mode, "HI" ----------------
    wr(1'b0, 8'h0E);
    base = upd_cnt;
    wr(1'b0, 8'h06);
    wr(1'b1, 8'h48);
    wr(1'b1, 8'h49);
    chk("upd_3", upd_cnt - base, 3);
    chk("disp_bits", {29'h0, display_on, cursor_on, blink_on}, 32'h6);
    chk("cursor_hi", {25'h0, cursor_addr}, 32'h02);
    chk_buf("buf0_H", 0, 8'h48);
    chk_buf("buf1_I", 1, 8'h49);

    // ---------------- line 1 and off-screen write ----------------
    wr(1'b0, 8'hC0);
    wr(1'b1, 8'h41);
    chk("cursor_41", {25'h0, cursor_addr}, 32'h41);
    chk_buf("buf16_A", 16, 8'h41);
    wr(1'b0, 8'h8F);
    wr(1'b1, 8'h5A);
    base = upd_cnt;
    wr(1'b1, 8'h59);
    chk("upd_offscreen", upd_cnt - base, 1);
    chk("cursor_11", {25'h0, cursor_addr}, 32'h11);
    chk_buf("buf15_Z", 15, 8'h5A);
    chk_buf("buf16_keep", 16, 8'h41);

    // function set and display shift are ignored (no update)
    base = upd_cnt;
    wr(1'b0, 8'h38);
    chk("upd_fset", upd_cnt - base, 0);
    wr(1'b0, 8'h14);
    chk("cursor_shift_r", {25'h0, cursor_addr}, 32'h12);
    base = upd_cnt;
    wr(1'b0, 8'h18);
    chk("upd_dshift", upd_cnt - base, 0);
    chk("cursor_dshift", {25'h0, cursor_addr}, 32'h12);

    // ---------------- decrement mode and wraps ----------------
    wr(1'b0, 8'h04);
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h51);
    chk("cursor_wrap_dec", {25'h0, cursor_addr}, 32'h67);
    chk_buf("buf0_Q", 0, 8'h51);
    wr(1'b0, 8'hA7);
    wr(1'b0, 8'h06);
    wr(1'b1, 8'h52);
    chk("cursor_wrap_inc", {25'h0, cursor_addr}, 32'h40);
    chk_buf("buf16_untouched", 16, 8'h41);
    wr(1'b1, 8'h53);
    chk_buf("buf16_S", 16, 8'h53);
    chk("cursor_41b", {25'h0, cursor_addr}, 32'h41);

    // ---------------- CGRAM mode discards data ----------------
    wr(1'b0, 8'h40);
    base = upd_cnt;
    wr(1'b1, 8'h77);
    chk("upd_cgram_data", upd_cnt - base, 0);
    chk("cursor_cgram", {25'h0, cursor_addr}, 32'h41);
    chk_buf("buf17_cgram", 17, 8'h20);
    wr(1'b0, 8'h02);
    chk("cursor_home", {25'h0, cursor_addr}, 32'h00);
    wr(1'b0, 8'h0D);
    chk("disp_bits2", {29'h0, display_on, cursor_on, blink_on}, 32'h5);

    // ---------------- clear with strobe while busy ----------------
    wr(1'b0, 8'h85);
    chk("cursor_85", {25'h0, cursor_addr}, 32'h05);
    @(negedge clk);
    lcd_rs = 1'b0;
    lcd_d  = 8'h01;
    lcd_e  = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e  = 1'b0;
    repeat (5) @(negedge clk);
    lcd_rs = 1'b1;
    lcd_d  = 8'h58;
    lcd_e  = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e  = 1'b0;
    chk("busy_during_clear", {31'h0, busy}, 32'h1);
    wait_idle("clear_timeout");
    chk("overrun_set", {31'h0, overrun}, 32'h1);
    chk("cursor_after_clear", {25'h0, cursor_addr}, 32'h00);
    chk_buf("clr_buf0", 0, 8'h20);
    chk_buf("clr_buf1", 1, 8'h20);
    chk_buf("clr_buf15", 15, 8'h20);
    chk_buf("clr_buf16", 16, 8'h20);

    // ---------------- reset in the middle of a clear ----------------
    @(negedge clk);
    lcd_rs = 1'b0;
    lcd_d  = 8'h01;
    lcd_e  = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e  = 1'b0;
    wait_busy_rise("busy_rise_timeout");
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("overrun_cleared", {31'h0, overrun}, 32'h0);
    reset = 1'b0;
    count_busy(nb);
    chk("clear_restart_len", nb, 32);
    chk("restart_cursor", {25'h0, cursor_addr}, 32'h00);
    chk("restart_disp", {31'h0, display_on}, 32'h0);
    chk_buf("restart_buf0", 0, 8'h20);
    chk_buf("restart_buf31", 31, 8'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
